ahbl_master: RTL and testbench
==============================

# ahbl_master

Single-clock AHB-Lite initiator that turns a simple valid/ready request stream into AHB-Lite SINGLE transfers and returns one response per request. It is the bus-master counterpart to the team's AHB-Lite peripherals (GPIO and others). It lets a local engine such as a test sequencer, DMA front-end or accelerator control unit read and write peripheral registers. The address and data phases are pipelined: a new address phase may overlap the previous data phase, including through wait states.

## Interface
- HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged data).
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HSIZE  out  3  {1'b0, req_size} of the address-phase transfer.
- HWRITE  out  1  address-phase direction.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  32  data-phase write data.
- HREADY  in  1  bus ready (from interconnect mux).
- HRESP  in  1  bus error response.
- HRDATA  in  32  read data.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on edge where req_valid & req_ready.
- req_write  in  1  1 = write.
- req_size  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word).
- req_addr  in  32  byte address; alignment to req_size is the requester's responsibility.
- req_wdata  in  32  lane-positioned write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  direction of the completed transfer.
- rsp_err  out  1  HRESP sampled at completion.
- rsp_rdata  out  32  raw HRDATA at completion (reads); 0 for writes.
- busy  out  1  an address or data phase is outstanding.

## Operation
- Two internal stages:
  - A (address phase): a_valid, addr, write, size, wdata.
  - D (data phase): d_valid, write, wdata.
- Drive: HTRANS = a_valid ? NONSEQ : IDLE; HADDR/HWRITE/HSIZE from A; HWDATA from D.
- req_ready = !a_valid | HREADY (combinational).
- Accept (req_valid & req_ready): A loads the request and a_valid = 1.
- Otherwise, if HREADY: a_valid clears.
- On every edge with HREADY = 1:
  - D takes A (d_valid <= a_valid).
  - If d_valid was set, the old D transfer completes. Next cycle: rsp_valid = 1, rsp_write = D.write, rsp_err = HRESP, rsp_rdata = D.write ? 0 : HRDATA.
- HREADY = 0: A and D hold; address-phase signals stay stable while a_valid.
  - Exception: an IDLE→NONSEQ change during wait states is permitted (new accept while a_valid = 0).
- Error (two-cycle HRESP): first cycle (HRESP = 1, HREADY = 0) is treated as a wait state. The pending A transfer is not cancelled; it proceeds normally. rsp_err = 1 only for the erroring transfer.
- Responses are returned strictly in request order. At most 2 transfers are outstanding.
- busy = a_valid | d_valid.

## Timing
- Reset (asynchronous, immediate) values:
  - HTRANS = IDLE; HADDR, HSIZE, HWRITE, HWDATA = 0.
  - rsp_valid, rsp_write, rsp_err, rsp_rdata, busy = 0.
  - a_valid = d_valid = 0, so req_ready = 1.
- Zero-wait latency, with accept at edge T:
  - Cycle T..T+1: NONSEQ on bus.
  - Cycle T+1..T+2: data phase, HWDATA valid.
  - Cycle T+2..T+3: rsp_valid high.
- Each HREADY = 0 cycle during either phase adds one cycle.
- Back-to-back with zero waits: one transfer per cycle; HTRANS stays NONSEQ continuously.
- Reset mid-operation: both stages are dropped, the bus returns to IDLE, and no response is issued for dropped transfers.

## Test plan
- Single write: req (write, addr 0x0000_0004, size 2, wdata 0xA5A5_5A5A) accepted at T, slave zero-wait.
  - Expect HTRANS = 2'b10 and HADDR = 0x4 in cycle T+1, HWDATA = 0xA5A5_5A5A in T+2.
  - Expect rsp_valid = 1, rsp_err = 0 in T+3 only.
- Read with 2 wait states: slave returns 0xBADD_BEEF.
  - Expect address/control stable during waits.
  - Expect rsp_valid at T+5 with rsp_rdata = 0xBADD_BEEF, rsp_write = 0.
- Back-to-back: 4 requests held valid (W 0x0, W 0x4, R 0x0, R 0x4), zero-wait slave.
  - Expect NONSEQ for 4 consecutive cycles, responses on 4 consecutive cycles in order.
  - Read data must equal the values previously written.
- Wait during pipelined pair: HREADY low for 3 cycles during the first data phase.
  - Expect req_ready = 0, second address held stable, no duplicated or lost response.
- Error: slave gives (HRESP = 1, HREADY = 0) then (HRESP = 1, HREADY = 1) on a write to 0xFFFF_0000, with a following read queued.
  - Expect rsp_err = 1 for the write.
  - Expect the following read to still complete with rsp_err = 0.
- Reset mid-transfer: assert HRESETn low during a data phase with a second request in A.
  - Expect HTRANS = IDLE and busy = 0 immediately, no rsp_valid.
  - Expect a new request after release to complete normally.

Source files
------------

// File: rtl/ahbl_master.sv
// AHB-Lite initiator: converts a valid/ready request stream into pipelined SINGLE
// transfers and returns one in-order response per request.
module ahbl_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESETn,

   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic        HWRITE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [31:0] HRDATA,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,

   output logic        rsp_valid,
   output logic        rsp_write,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        busy
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic        a_valid;
   logic [31:0] a_addr;
   logic        a_write;
   logic [2:0]  a_size;
   logic [31:0] a_wdata;

   logic        d_valid;
   logic        d_write;
   logic [31:0] d_wdata;

   logic        accept;
   logic        complete;
   logic [2:0]  req_hsize;

   assign req_ready = !a_valid | HREADY;
   assign accept    = req_valid & req_ready;
   assign complete  = HREADY & d_valid;

   // size 3 has no meaning on this bus; issue it as a word
   assign req_hsize = (req_size == 2'b11) ? 3'b010 : {1'b0, req_size};

   // address stage: loads on accept, otherwise drains when the bus advances
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid <= 1'b0;
         a_addr  <= '0;
         a_write <= 1'b0;
         a_size  <= '0;
         a_wdata <= '0;
      end else if (accept) begin
         a_valid <= 1'b1;
         a_addr  <= req_addr;
         a_write <= req_write;
         a_size  <= req_hsize;
         a_wdata <= req_wdata;
      end else if (HREADY) begin
         a_valid <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         d_valid <= 1'b0;
         d_write <= 1'b0;
         d_wdata <= '0;
      end else if (HREADY) begin
         d_valid <= a_valid;
         d_write <= a_write;
         d_wdata <= a_wdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else if (complete) begin
         rsp_valid <= 1'b1;
         rsp_write <= d_write;
         rsp_err   <= HRESP;
         rsp_rdata <= d_write ? 32'h0 : HRDATA;
      end else begin
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end
   end

   assign HTRANS = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR  = a_addr;
   assign HWRITE = a_write;
   assign HSIZE  = a_size;
   assign HWDATA = d_wdata;
   assign HBURST = 3'b000;
   assign HPROT  = HPROT_VAL;
   assign busy   = a_valid | d_valid;

endmodule

// File: tb/tb_ahbl_master.sv
// Directed bench for ahbl_master: a small memory slave on the bus, a response
// scoreboard queue and directed cycle checks on the bus signals.
module tb_ahbl_master;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_write;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        busy;

   ahbl_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
      .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata), .busy(busy)
   );

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic        w;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // memory slave: captures address phases, stores write data at completion
   logic [31:0] mem [16];
   logic        dp_valid;
   logic        dp_write;
   logic [31:0] dp_addr;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[2]   <= 32'hBADD_BEEF;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 32'h0;
      end else if (HREADY) begin
         if (dp_valid && dp_write && !HRESP) mem[dp_addr[5:2]] <= HWDATA;
         dp_valid <= (HTRANS == 2'b10);
         dp_write <= HWRITE;
         dp_addr  <= HADDR;
      end
   end

   assign HRDATA = mem[dp_addr[5:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge HCLK) begin
      if (HRESETn && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got write=%0b err=%0b rdata=0x%08h, want none",
                     rsp_write, rsp_err, rsp_rdata);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_write", {31'h0, rsp_write}, {31'h0, e.w});
            chk("rsp_err",   {31'h0, rsp_err},   {31'h0, e.err});
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic put_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
      req_valid = 1'b1;
      req_write = w;
      req_size  = sz;
      req_addr  = a;
      req_wdata = wd;
   endtask

   task automatic expect_rsp(input logic w, input logic err, input logic [31:0] rd);
      rsp_t e;
      e.w     = w;
      e.err   = err;
      e.rdata = rd;
      exp_q.push_back(e);
   endtask

   // returns one time unit after the edge on which the pending request was taken
   task automatic accept_wait(input string nm);
      logic rdy;
      int   n;
      rdy = 1'b0;
      n   = 0;
      do begin
         @(negedge HCLK);
         rdy = req_ready;
         @(posedge HCLK);
         #1;
         n++;
      end while (!rdy && n < 20);
      chk(nm, {31'h0, rdy}, 32'h1);
   endtask

   logic        bw   [4];
   logic [1:0]  bsz  [4];
   logic [31:0] ba   [4];
   logic [31:0] bd   [4];
   logic [31:0] bexp [4];
   logic [2:0]  bhs  [4];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      HREADY  = 1'b1;
      HRESP   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size  = 2'b00;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      #3;
      chk("rst_htrans",  {30'h0, HTRANS}, 32'h0);
      chk("rst_haddr",   HADDR, 32'h0);
      chk("rst_hsize",   {29'h0, HSIZE}, 32'h0);
      chk("rst_hwrite",  {31'h0, HWRITE}, 32'h0);
      chk("rst_hwdata",  HWDATA, 32'h0);
      chk("rst_rsp",     {28'h0, rsp_valid, rsp_write, rsp_err, busy}, 32'h0);
      chk("rst_rdata",   rsp_rdata, 32'h0);
      chk("rst_ready",   {31'h0, req_ready}, 32'h1);
      chk("hburst",      {29'h0, HBURST}, 32'h0);
      chk("hprot",       {28'h0, HPROT}, 32'h3);
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      // single zero-wait write
      put_req(1'b1, 2'd2, 32'h0000_0004, 32'hA5A5_5A5A);
      expect_rsp(1'b1, 1'b0, 32'h0);
      accept_wait("t1_accept");
      req_valid = 1'b0;
      chk("t1_htrans", {30'h0, HTRANS}, 32'h2);
      chk("t1_haddr",  HADDR, 32'h4);
      chk("t1_ctrl",   {28'h0, HWRITE, HSIZE}, 32'hA);
      step();
      chk("t1_hwdata", HWDATA, 32'hA5A5_5A5A);
      chk("t1_idle",   {30'h0, HTRANS}, 32'h0);
      chk("t1_norsp",  {31'h0, rsp_valid}, 32'h0);
      step();
      chk("t1_rsp",    {30'h0, rsp_valid, rsp_err}, 32'h2);
      step();
      chk("t1_rspend", {30'h0, rsp_valid, busy}, 32'h0);

      // read with two wait states, address phase held
      put_req(1'b0, 2'd2, 32'h0000_0008, 32'h0);
      expect_rsp(1'b0, 1'b0, 32'hBADD_BEEF);
      accept_wait("t2_accept");
      req_valid = 1'b0;
      chk("t2_htrans", {30'h0, HTRANS}, 32'h2);
      HREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t2_hold_addr", HADDR, 32'h8);
         chk("t2_hold_ctrl", {27'h0, HTRANS, HWRITE, HSIZE}, {27'h0, 2'b10, 1'b0, 3'b010});
      end
      HREADY = 1'b1;
      step();
      chk("t2_norsp", {31'h0, rsp_valid}, 32'h0);
      step();
      chk("t2_rsp",   {31'h0, rsp_valid}, 32'h1);
      step();
      chk("t2_rspend", {31'h0, rsp_valid}, 32'h0);

      // back-to-back, zero-wait, reads return prior writes
      bw[0] = 1'b1; bsz[0] = 2'd2; ba[0] = 32'h0; bd[0] = 32'h1111_0000; bexp[0] = 32'h0;          bhs[0] = 3'd2;
      bw[1] = 1'b1; bsz[1] = 2'd3; ba[1] = 32'h4; bd[1] = 32'h2222_0004; bexp[1] = 32'h0;          bhs[1] = 3'd2;
      bw[2] = 1'b0; bsz[2] = 2'd2; ba[2] = 32'h0; bd[2] = 32'h0;         bexp[2] = 32'h1111_0000;  bhs[2] = 3'd2;
      bw[3] = 1'b0; bsz[3] = 2'd1; ba[3] = 32'h4; bd[3] = 32'h0;         bexp[3] = 32'h2222_0004;  bhs[3] = 3'd1;
      for (int i = 0; i < 4; i++) begin
         put_req(bw[i], bsz[i], ba[i], bd[i]);
         expect_rsp(bw[i], 1'b0, bexp[i]);
         accept_wait("t3_accept");
         chk("t3_nonseq", {30'h0, HTRANS}, 32'h2);
         chk("t3_haddr",  HADDR, ba[i]);
         chk("t3_hsize",  {29'h0, HSIZE}, {29'h0, bhs[i]});
         if (i >= 2) chk("t3_rsp_run", {31'h0, rsp_valid}, 32'h1);
      end
      req_valid = 1'b0;
      step();
      chk("t3_rsp_run", {31'h0, rsp_valid}, 32'h1);
      chk("t3_idle",    {30'h0, HTRANS}, 32'h0);
      step();
      chk("t3_rsp_run", {31'h0, rsp_valid}, 32'h1);
      step();
      chk("t3_rspend",  {30'h0, rsp_valid, busy}, 32'h0);

      // three wait states during the first data phase of a pipelined pair
      put_req(1'b1, 2'd2, 32'h8, 32'h3333_3333);
      expect_rsp(1'b1, 1'b0, 32'h0);
      accept_wait("t4_accept_a");
      put_req(1'b0, 2'd2, 32'h8, 32'h0);
      expect_rsp(1'b0, 1'b0, 32'h3333_3333);
      accept_wait("t4_accept_b");
      put_req(1'b0, 2'd2, 32'h4, 32'h0);
      expect_rsp(1'b0, 1'b0, 32'h2222_0004);
      HREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_ready_low", {31'h0, req_ready}, 32'h0);
         chk("t4_hold_addr", HADDR, 32'h8);
         chk("t4_hold_ctrl", {29'h0, HTRANS, HWRITE}, {29'h0, 2'b10, 1'b0});
         chk("t4_norsp",     {31'h0, rsp_valid}, 32'h0);
      end
      HREADY = 1'b1;
      accept_wait("t4_accept_c");
      req_valid = 1'b0;
      chk("t4_rsp_a", {31'h0, rsp_valid}, 32'h1);
      chk("t4_haddr_c", HADDR, 32'h4);
      step();
      chk("t4_rsp_b", {31'h0, rsp_valid}, 32'h1);
      step();
      chk("t4_rsp_c", {31'h0, rsp_valid}, 32'h1);
      step();
      chk("t4_rspend", {30'h0, rsp_valid, busy}, 32'h0);

      // two-cycle error on a write, following read unaffected
      put_req(1'b1, 2'd2, 32'hFFFF_0000, 32'hDEAD_0000);
      expect_rsp(1'b1, 1'b1, 32'h0);
      accept_wait("t5_accept_w");
      put_req(1'b0, 2'd2, 32'h4, 32'h0);
      expect_rsp(1'b0, 1'b0, 32'h2222_0004);
      accept_wait("t5_accept_r");
      req_valid = 1'b0;
      HREADY = 1'b0;
      HRESP  = 1'b1;
      step();
      chk("t5_norsp",  {31'h0, rsp_valid}, 32'h0);
      chk("t5_hold",   HADDR, 32'h4);
      chk("t5_nonseq", {30'h0, HTRANS}, 32'h2);
      HREADY = 1'b1;
      step();
      chk("t5_err_rsp", {30'h0, rsp_valid, rsp_err}, 32'h3);
      HRESP = 1'b0;
      step();
      chk("t5_read_rsp", {30'h0, rsp_valid, rsp_err}, 32'h2);
      step();
      chk("t5_rspend", {30'h0, rsp_valid, busy}, 32'h0);

      // reset with one transfer in D and one in A
      put_req(1'b1, 2'd2, 32'hC, 32'h4444_4444);
      accept_wait("t6_accept_w");
      put_req(1'b0, 2'd2, 32'h0, 32'h0);
      accept_wait("t6_accept_r");
      req_valid = 1'b0;
      chk("t6_busy_pre", {31'h0, busy}, 32'h1);
      HRESETn = 1'b0;
      #1;
      chk("t6_htrans", {30'h0, HTRANS}, 32'h0);
      chk("t6_busy",   {31'h0, busy}, 32'h0);
      chk("t6_rsp",    {31'h0, rsp_valid}, 32'h0);
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      put_req(1'b0, 2'd2, 32'h8, 32'h0);
      expect_rsp(1'b0, 1'b0, 32'hBADD_BEEF);
      accept_wait("t6_accept_new");
      req_valid = 1'b0;
      step();
      step();
      chk("t6_new_rsp", {31'h0, rsp_valid}, 32'h1);
      step();
      step();
      chk("drained", exp_q.size(), 32'h0);
      chk("idle_end", {30'h0, busy, rsp_valid}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
